seven_seg_scanner: RTL

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner_pkg.sv | 21 ++
 rtl/seven_seg_scanner_seg_hex_lut.sv | 11 +
 rtl/seven_seg_scanner.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/seven_seg_scanner_pkg.sv
// Shared definitions for the seven-segment scanner: register map, CTRL fields,
// the dark segment pattern and the hex-to-segment table (active-low {g,f,e,d,c,b,a}).
package seven_seg_scanner_pkg;

  localparam logic [1:0] ADDR_DIGITS   = 2'd0;
  localparam logic [1:0] ADDR_CTRL     = 2'd1;
  localparam logic [1:0] ADDR_PRESCALE = 2'd2;
  localparam logic [1:0] ADDR_STATUS   = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MASK_LSB = 4;
  localparam int CTRL_DP_LSB   = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] HEX_SEG_TABLE [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seven_seg_scanner_seg_hex_lut.sv
// Combinational hex nibble to active-low seven-segment decode.
module seg_hex_lut
  import seven_seg_scanner_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_segs
);

  assign o_segs = HEX_SEG_TABLE[i_nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Avalon-MM controlled four-digit multiplexed seven-segment scanner with
// per-digit blanking, decimal points and an anti-ghost blank after each digit change.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int CLK_DIV_DEFAULT = 50000,
  parameter int NUM_DIGITS      = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write,
  input  logic [31:0]           writedata,
  input  logic                  read,
  output logic [31:0]           readdata,
  output logic [6:0]            segs,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] digit_en_n
);

  localparam logic [15:0] PRESCALE_RST = 16'(CLK_DIV_DEFAULT);

  logic [15:0]           r_digits;
  logic                  r_en;
  logic [3:0]            r_mask;
  logic [3:0]            r_dpm;
  logic [15:0]           r_prescale;
  logic [15:0]           r_cnt;
  logic [1:0]            r_idx;
  logic                  r_ghost;
  logic [31:0]           r_rdata;
  logic [6:0]            r_segs;
  logic                  r_dp;
  logic [NUM_DIGITS-1:0] r_dig_en_n;

  logic                  w_wr_digits;
  logic                  w_wr_ctrl;
  logic                  w_wr_prescale;
  logic                  w_rd;
  logic                  w_reenable;
  logic [15:0]           w_dwell_last;
  logic                  w_adv;
  logic                  w_ghost;
  logic                  w_lit;
  logic [3:0]            w_nibble;
  logic [6:0]            w_lut_segs;
  logic [NUM_DIGITS-1:0] w_sel;
  logic [31:0]           w_rd_mux;
  logic                  w_unused_wdata;

  assign w_wr_digits   = chipselect && write && (address == ADDR_DIGITS);
  assign w_wr_ctrl     = chipselect && write && (address == ADDR_CTRL);
  assign w_wr_prescale = chipselect && write && (address == ADDR_PRESCALE);
  assign w_rd          = chipselect && read;
  assign w_reenable    = w_wr_ctrl && !r_en && writedata[CTRL_EN_BIT];
  assign w_unused_wdata = ^{writedata[31:16], writedata[3:1]};

  // A prescale of 0 behaves as 1, so the last dwell count is 0 in both cases.
  assign w_dwell_last = (r_prescale == 16'd0) ? 16'd0 : r_prescale - 16'd1;
  assign w_adv        = r_en && !w_wr_prescale && (r_cnt >= w_dwell_last);
  // Anti-ghost blank; never two in a row, so a one-cycle dwell still alternates lit/dark.
  assign w_ghost      = w_adv && !r_ghost;
  assign w_lit        = r_en && !r_mask[r_idx] && !w_ghost;

  assign w_nibble = r_digits[{r_idx, 2'b00} +: 4];
  assign w_sel    = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;

  seg_hex_lut u_lut (
    .i_nibble (w_nibble),
    .o_segs   (w_lut_segs)
  );

  always_comb begin
    w_rd_mux = 32'd0;
    case (address)
      ADDR_DIGITS:   w_rd_mux = {16'd0, r_digits};
      ADDR_CTRL:     w_rd_mux = {20'd0, r_dpm, r_mask, 3'd0, r_en};
      ADDR_PRESCALE: w_rd_mux = {16'd0, r_prescale};
      default:       w_rd_mux = {29'd0, r_en, r_idx};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_digits   <= 16'd0;
      r_en       <= 1'b0;
      r_mask     <= 4'd0;
      r_dpm      <= 4'd0;
      r_prescale <= PRESCALE_RST;
      r_rdata    <= 32'd0;
    end else begin
      if (w_wr_digits) r_digits <= writedata[15:0];
      if (w_wr_ctrl) begin
        r_en   <= writedata[CTRL_EN_BIT];
        r_mask <= writedata[CTRL_MASK_LSB +: 4];
        r_dpm  <= writedata[CTRL_DP_LSB +: 4];
      end
      if (w_wr_prescale) r_prescale <= writedata[15:0];
      if (w_rd) r_rdata <= w_rd_mux;
    end
  end

  // Dwell counter and digit index; both hold while disabled.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt   <= 16'd0;
      r_idx   <= 2'd0;
      r_ghost <= 1'b0;
    end else begin
      r_ghost <= w_ghost;
      if (w_wr_prescale || w_reenable) begin
        r_cnt <= 16'd0;
      end else if (w_adv) begin
        r_cnt <= 16'd0;
        r_idx <= r_idx + 2'd1;
      end else if (r_en) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_segs     <= SEG_BLANK;
      r_dp       <= 1'b1;
      r_dig_en_n <= '1;
    end else if (w_lit) begin
      r_segs     <= w_lut_segs;
      r_dp       <= ~r_dpm[r_idx];
      r_dig_en_n <= ~w_sel;
    end else begin
      r_segs     <= SEG_BLANK;
      r_dp       <= 1'b1;
      r_dig_en_n <= '1;
    end
  end

  assign readdata   = r_rdata;
  assign segs       = r_segs;
  assign dp         = r_dp;
  assign digit_en_n = r_dig_en_n;

endmodule
